// File: rtl/uart_rx_if.sv
// UART receiver signal bundle: serial line in, byte strobe out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] op_data;
  logic       op_flag;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  op_data,
    input  op_flag,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output op_data,
    output op_flag,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: sync rx, find start edge, sample mid-bit,
// check stop bit and strobe each good byte for one cycle.
module uart_rx #(
  parameter logic [15:0] BAUD_CNT_MAX = 16'd13_020,
  parameter logic [15:0] SAMPLE_PT    = BAUD_CNT_MAX / 16'd2
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        flag_q, flag_d;
  logic        ferr_q, ferr_d;
  logic        fall;
  logic        strobe;

  assign fall   = rx_s3_q & ~rx_s2_q;
  assign strobe = (baud_cnt_q == SAMPLE_PT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= bus.rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      flag_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    flag_d    = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (strobe) begin
          bit_cnt_d = '0;
          state_d   = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is caught.
        if (strobe) begin
          state_d = IDLE;
          if (rx_s2_q) begin
            data_d = shift_q;
            flag_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_d == IDLE)
      baud_cnt_d = '0;
    else if (baud_cnt_q == BAUD_CNT_MAX)
      baud_cnt_d = '0;
    else
      baud_cnt_d = baud_cnt_q + 16'd1;
  end

  assign bus.op_data   = data_q;
  assign bus.op_flag   = flag_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
